// File: rtl/serdes_pkg.sv
// Shared definitions for secure_serdes_encryptor: FSM encodings, default key, parameter check.
// The PARITY state exists only when SERDES_PARITY_EN is defined.
package serdes_pkg;

  localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
  localparam logic [2:0] ST_SHIFT_ENC   = 3'd1;
  localparam logic [2:0] ST_ENCRYPT_ENC = 3'd2;
  localparam logic [2:0] ST_OUTPUT_ENC  = 3'd3;
  localparam logic [2:0] ST_PARITY_ENC  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE_ENC,
    S_SHIFT   = ST_SHIFT_ENC,
    S_ENCRYPT = ST_ENCRYPT_ENC,
    S_OUTPUT  = ST_OUTPUT_ENC
`ifdef SERDES_PARITY_EN
    , S_PARITY = ST_PARITY_ENC
`endif
  } state_t;

  localparam logic [127:0] DEFAULT_KEY = 128'hA1B2_C3D4_E5F6_0123_4567_89AB_CDEF_1234;

  function automatic bit serdes_params_ok(input int data_w, input int key_w, input int frame_len);
    return (data_w >= 2) && (key_w >= data_w) && ((key_w % data_w) == 0) && (frame_len >= 1);
  endfunction

endpackage

// File: rtl/serdes_key_sched.sv
// Key register for secure_serdes_encryptor: load on frame start, rotate right by one word, clear on abort.
module serdes_key_sched
  import serdes_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int KEY_W  = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              rotate,
  input  logic              clear,
  input  logic [KEY_W-1:0]  key_in,
  output logic [DATA_W-1:0] slice
);

  logic [KEY_W-1:0] key_r;

  // Key register; clear wins over load, load over rotate
  always_ff @(posedge clk) begin
    if (rst) begin
      key_r <= '0;
    end else if (clear) begin
      key_r <= '0;
    end else if (load) begin
      key_r <= key_in;
    end else if (rotate) begin
      key_r <= (key_r >> DATA_W) | (key_r << (KEY_W - DATA_W));
    end else begin
      key_r <= key_r;
    end
  end

  assign slice = key_r[DATA_W-1:0];

endmodule

// File: rtl/secure_serdes_encryptor.sv
// Deserialise two MSB-first streams, XOR each word pair with a rotating key slice, reserialise.
// Define SERDES_PARITY_EN to append an even-parity bit after every word.
module secure_serdes_encryptor
  import serdes_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int KEY_W     = 128,
  parameter int FRAME_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [KEY_W-1:0] key,
  input  logic             in_valid,
  input  logic             a_bit,
  input  logic             b_bit,
  output logic             cipher_out,
  output logic             cipher_valid,
  output logic             busy,
  output logic             done
);

  localparam int BCW = $clog2(DATA_W + 1);
  localparam int WIW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BCW-1:0] BC_LAST = BCW'(DATA_W - 1);
  localparam logic [BCW-1:0] BC_FULL = BCW'(DATA_W);
  localparam logic [WIW-1:0] WI_LAST = WIW'(FRAME_LEN - 1);

  if (!serdes_params_ok(DATA_W, KEY_W, FRAME_LEN)) begin : g_param_check
    $error("secure_serdes_encryptor: illegal DATA_W/KEY_W/FRAME_LEN combination");
  end

  state_t            state_r, state_nxt_s;
  logic [DATA_W-1:0] a_r, a_nxt_s, b_r, b_nxt_s, word_r, word_nxt_s, slice_s;
  logic [BCW-1:0]    bit_cnt_r, bit_cnt_nxt_s;
  logic [WIW-1:0]    word_idx_r, word_idx_nxt_s;
  logic              cipher_out_nxt_s, cipher_valid_nxt_s, busy_nxt_s, done_nxt_s;
  logic              key_load_s, key_rotate_s, key_clear_s;
`ifdef SERDES_PARITY_EN
  logic              parity_r, parity_nxt_s;

  function automatic logic word_parity(input logic [DATA_W-1:0] w);
    return ^w;
  endfunction
`endif

  serdes_key_sched #(.DATA_W(DATA_W), .KEY_W(KEY_W)) u_key_sched (
    .clk    (clk),
    .rst    (rst),
    .load   (key_load_s),
    .rotate (key_rotate_s),
    .clear  (key_clear_s),
    .key_in (key),
    .slice  (slice_s)
  );

  // Next-state, datapath and output decode
  always_comb begin
    state_nxt_s        = state_r;
    a_nxt_s            = a_r;
    b_nxt_s            = b_r;
    word_nxt_s         = word_r;
    bit_cnt_nxt_s      = bit_cnt_r;
    word_idx_nxt_s     = word_idx_r;
    cipher_out_nxt_s   = 1'b0;
    cipher_valid_nxt_s = 1'b0;
    busy_nxt_s         = 1'b1;
    done_nxt_s         = done;
    key_load_s         = 1'b0;
    key_rotate_s       = 1'b0;
    key_clear_s        = 1'b0;
`ifdef SERDES_PARITY_EN
    parity_nxt_s       = parity_r;
`endif
    if ((state_r != S_IDLE) && abort) begin
      state_nxt_s = S_IDLE;
      busy_nxt_s  = 1'b0;
      key_clear_s = 1'b1;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            key_load_s     = 1'b1;
            word_idx_nxt_s = '0;
            bit_cnt_nxt_s  = '0;
            a_nxt_s        = '0;
            b_nxt_s        = '0;
            done_nxt_s     = 1'b0;
            state_nxt_s    = S_SHIFT;
          end else begin
            busy_nxt_s = 1'b0;
          end
        end
        S_SHIFT: begin
          if (in_valid) begin
            a_nxt_s       = {a_r[DATA_W-2:0], a_bit};
            b_nxt_s       = {b_r[DATA_W-2:0], b_bit};
            bit_cnt_nxt_s = bit_cnt_r + BCW'(1);
            if (bit_cnt_r == BC_LAST) begin
              state_nxt_s = S_ENCRYPT;
            end else begin
              state_nxt_s = S_SHIFT;
            end
          end else begin
            state_nxt_s = S_SHIFT;
          end
        end
        S_ENCRYPT: begin
          word_nxt_s    = a_r ^ b_r ^ slice_s;
`ifdef SERDES_PARITY_EN
          parity_nxt_s  = word_parity(a_r ^ b_r ^ slice_s);
`endif
          key_rotate_s  = 1'b1;
          bit_cnt_nxt_s = '0;
          state_nxt_s   = S_OUTPUT;
        end
        S_OUTPUT: begin
          // bit_cnt == DATA_W only after the final word: one drain cycle so done lands with valid falling
          if (bit_cnt_r == BC_FULL) begin
            state_nxt_s = S_IDLE;
            busy_nxt_s  = 1'b0;
            done_nxt_s  = 1'b1;
          end else begin
            cipher_out_nxt_s   = word_r[DATA_W-1];
            cipher_valid_nxt_s = 1'b1;
            word_nxt_s         = {word_r[DATA_W-2:0], 1'b0};
            bit_cnt_nxt_s      = bit_cnt_r + BCW'(1);
            if (bit_cnt_r == BC_LAST) begin
`ifdef SERDES_PARITY_EN
              state_nxt_s   = S_PARITY;
              bit_cnt_nxt_s = '0;
`else
              if (word_idx_r == WI_LAST) begin
                state_nxt_s = S_OUTPUT;
              end else begin
                word_idx_nxt_s = word_idx_r + WIW'(1);
                a_nxt_s        = '0;
                b_nxt_s        = '0;
                bit_cnt_nxt_s  = '0;
                state_nxt_s    = S_SHIFT;
              end
`endif
            end else begin
              state_nxt_s = S_OUTPUT;
            end
          end
        end
`ifdef SERDES_PARITY_EN
        S_PARITY: begin
          if (bit_cnt_r != '0) begin
            state_nxt_s = S_IDLE;
            busy_nxt_s  = 1'b0;
            done_nxt_s  = 1'b1;
          end else begin
            cipher_out_nxt_s   = parity_r;
            cipher_valid_nxt_s = 1'b1;
            if (word_idx_r == WI_LAST) begin
              bit_cnt_nxt_s = BCW'(1);
              state_nxt_s   = S_PARITY;
            end else begin
              word_idx_nxt_s = word_idx_r + WIW'(1);
              a_nxt_s        = '0;
              b_nxt_s        = '0;
              bit_cnt_nxt_s  = '0;
              state_nxt_s    = S_SHIFT;
            end
          end
        end
`endif
        default: begin
          state_nxt_s = S_IDLE;
          busy_nxt_s  = 1'b0;
        end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r          <= '0;
      b_r          <= '0;
      word_r       <= '0;
      bit_cnt_r    <= '0;
      word_idx_r   <= '0;
      cipher_out   <= 1'b0;
      cipher_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef SERDES_PARITY_EN
      parity_r     <= 1'b0;
`endif
    end else begin
      a_r          <= a_nxt_s;
      b_r          <= b_nxt_s;
      word_r       <= word_nxt_s;
      bit_cnt_r    <= bit_cnt_nxt_s;
      word_idx_r   <= word_idx_nxt_s;
      cipher_out   <= cipher_out_nxt_s;
      cipher_valid <= cipher_valid_nxt_s;
      busy         <= busy_nxt_s;
      done         <= done_nxt_s;
`ifdef SERDES_PARITY_EN
      parity_r     <= parity_nxt_s;
`endif
    end
  end

endmodule
